ram_port_arbiter: RTL

Two-requester arbiter that shares the single `ram32` port between two memory clients, for example an instruction-side and a data-side `sa_cache` instance. It does round-robin ownership with optional lock for multi-beat line refills and writebacks, and enforces a bounded lock length. It drives the RAM command signals and returns read data with a per-requester valid one cycle after the read beat, matching the `ram32` synchronous-read latency.

---
 rtl/ram_port_arbiter.sv | 95 +++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin sharing of one ram32 port between two clients,
// with burst locking bounded to MAX_LOCK beats while the other side waits.
module ram_port_arbiter #(
    parameter int ADDR_W   = 20,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic              we0,
    input  logic              we1,
    input  logic [3:0]        be0,
    input  logic [3:0]        be1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              WE,
    output logic [3:0]        BE,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data_w,
    input  logic [DATA_W-1:0] ram_data_r
);
    localparam int CW = $clog2(MAX_LOCK + 1);
    localparam logic [CW:0]   MAX_W = (CW + 1)'(MAX_LOCK);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_LOCK);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t        state, state_n;
    logic          last, last_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [CW:0]   inc;
    logic          acc0, acc1, req_o, lock_o, req_x, at_max, rel;

    assign gnt0   = state == OWN0;
    assign gnt1   = state == OWN1;
    assign acc0   = gnt0 && req0;
    assign acc1   = gnt1 && req1;
    assign req_o  = gnt0 ? req0 : req1;
    assign lock_o = gnt0 ? lock0 : lock1;
    assign req_x  = gnt0 ? req1 : req0;
    assign inc    = {1'b0, cnt} + (CW + 1)'(1);
    assign at_max = inc >= MAX_W;
    // a held lock only yields once the bound is hit and someone is waiting
    assign rel    = !req_o || !lock_o || (at_max && req_x);

    always_comb begin
        state_n = state;
        last_n  = last;
        cnt_n   = cnt;
        if (!(gnt0 || gnt1)) begin
            state_n = (req0 && req1) ? (last ? OWN0 : OWN1) :
                      req0 ? OWN0 : req1 ? OWN1 : IDLE;
            cnt_n   = '0;
        end else if (rel) begin
            state_n = req_x ? (gnt0 ? OWN1 : OWN0) : IDLE;
            last_n  = gnt1;
            cnt_n   = '0;
        end else begin
            cnt_n   = at_max ? MAX_C : inc[CW-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            last    <= 1'b1;
            cnt     <= '0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            state   <= state_n;
            last    <= last_n;
            cnt     <= cnt_n;
            rvalid0 <= acc0 && !we0;
            rvalid1 <= acc1 && !we1;
        end
    end

    assign WE         = acc0 ? we0 : (acc1 && we1);
    assign BE         = (acc0 && we0) ? be0 : (acc1 && we1) ? be1 : 4'b0;
    assign ram_addr   = acc0 ? addr0 : acc1 ? addr1 : '0;
    assign ram_data_w = acc0 ? wdata0 : acc1 ? wdata1 : '0;
    assign rdata      = ram_data_r;
endmodule
